load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  core requests an access; sampled only while ready=1.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data, right-justified.
REQ-009 SHALL have port ready  output  1  unit idle, can accept req.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  valid with done: misaligned or illegal funct3.
REQ-012 SHALL have port rdata  output  32  load result, extended to 32 bits, held until next done.
REQ-013 SHALL have port MemRead  output  1  data-memory read enable.
REQ-014 SHALL have port MemWrite  output  1  data-memory write enable.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word address = addr[ADDR_W+1:2].
REQ-016 SHALL have port mem_wdata  output  32  word to write.
REQ-017 SHALL have port mem_rdata  input  32  combinational memory read data.

Function
REQ-018 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP.
REQ-019 ready SHALL be 1 exactly in IDLE; req while not ready SHALL be ignored.
REQ-020 On req in IDLE, SHALL latch we, funct3, addr, wdata.
REQ-021 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or illegal (011,110,111; 100/101 with we=1) SHALL go IDLE->RESP with err=1, no memory access.
REQ-022 Legal load: IDLE->RD->RESP; in RD, MemRead=1 and mem_rdata captured at end of RD.
REQ-023 Legal SW: IDLE->WR->RESP, mem_wdata=wdata.
REQ-024 Legal SB/SH: IDLE->RMW_RD->WR->RESP; RMW_RD reads word, WR writes merged word.
REQ-025 Merge: SB replaces byte lane addr[1:0] with wdata[7:0]; SH replaces halfword addr[1] with wdata[15:0]; other bits unchanged.
REQ-026 Extract: B/H sign-extend selected lane, BU/HU zero-extend, W passes word.
REQ-027 done SHALL be 1 only in RESP; latency req-to-done: error 1, load/SW 2, SB/SH 3 cycles.
REQ-028 MemRead, MemWrite, mem_addr, mem_wdata SHALL be registered outputs, stable for the whole RD/RMW_RD/WR cycle; MemRead and MemWrite never both 1.
REQ-029 MemRead=0, MemWrite=0 outside RD/RMW_RD/WR; mem_wdata=0 outside WR.
REQ-030 rdata SHALL update only on successful load completion; stores and errors leave it unchanged.
REQ-031 A req present in RESP SHALL be ignored; next accept earliest the cycle after RESP.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, ready=1, done=0, err=0, rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-operation SHALL abandon the access; a write is either fully issued or not issued, never partial.

Structure
REQ-034 Package lsu_pkg SHALL hold funct3 constants and the FSM state enum.
REQ-035 Combinational sub-module lsu_align SHALL perform lane merge (store) and extract/extend (load).

Verification
REQ-036 Memory word 5 = 0x8899AABB; load funct3=000 addr=0x16 -> done at cycle 2, rdata=0xFFFFFF99, err=0.
REQ-037 Same word; funct3=101 addr=0x16 -> rdata=0x00008899; funct3=010 addr=0x14 -> rdata=0x8899AABB.
REQ-038 Word 5 = 0x8899AABB; SB addr=0x15 wdata=0x123456CC -> RMW_RD, WR with mem_wdata=0x8899CCBB, done at cycle 3.
REQ-039 SW addr=0x12 -> done cycle 1, err=1, MemRead/MemWrite never asserted, rdata unchanged.
REQ-040 reset_n low during WR of an SH -> MemWrite drops immediately, ready=1, next LW completes normally.
REQ-041 req held high continuously -> accepts every 3rd cycle for LW, never while ready=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, FSM state encoding and access-legality check for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W_BITS = 3;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  // Misaligned halfword/word, unknown width code, or unsigned width on a store.
  function automatic logic access_bad(input logic [F3_W_BITS-1:0] f3,
                                      input logic                 is_store,
                                      input logic [1:0]           off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: merges store data into a memory word and extracts/extends load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3_W_BITS-1:0] funct3,
  input  logic [1:0]           off,
  input  logic [DATA_W-1:0]    store_data,
  input  logic [DATA_W-1:0]    mem_word,
  output logic [DATA_W-1:0]    store_word_c,
  output logic [DATA_W-1:0]    load_word_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane    = mem_word[{off, 3'b000} +: 8];
    half_lane    = off[1] ? mem_word[31:16] : mem_word[15:0];

    store_word_c = mem_word;
    case (funct3)
      F3_B:    store_word_c[{off, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    store_word_c[{off[1], 4'b0000} +: 16] = store_data[15:0];
      F3_W:    store_word_c = store_data;
      default: store_word_c = mem_word;
    endcase

    case (funct3)
      F3_B:    load_word_c = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_word_c = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_word_c = {24'd0, byte_lane};
      F3_HU:   load_word_c = {16'd0, half_lane};
      default: load_word_c = mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word-addressed data memory, sub-word stores via read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [F3_W_BITS-1:0] funct3,
  input  logic [31:0]          addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 ready,
  output logic                 done,
  output logic                 err,
  output logic [DATA_W-1:0]    rdata,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  state_t                 state;
  logic [F3_W_BITS-1:0]   lat_f3;
  logic [1:0]             lat_off;
  logic [DATA_W-1:0]      lat_wdata;
  logic [DATA_W-1:0]      store_word_c;
  logic [DATA_W-1:0]      load_word_c;

  // Address bits above the memory window do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  lsu_align u_align (
    .funct3       (lat_f3),
    .off          (lat_off),
    .store_data   (lat_wdata),
    .mem_word     (mem_rdata),
    .store_word_c (store_word_c),
    .load_word_c  (load_word_c)
  );

  // Enables and write data default low every cycle so they can only be high in an access state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
      lat_wdata <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_f3    <= funct3;
            lat_off   <= addr[1:0];
            lat_wdata <= wdata;
            mem_addr  <= addr[ADDR_W+1:2];
            ready     <= 1'b0;
            if (access_bad(funct3, we, addr[1:0])) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!we) begin
              state   <= RD;
              MemRead <= 1'b1;
            end else if (funct3 == F3_W) begin
              state     <= WR;
              MemWrite  <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state   <= RMW_RD;
              MemRead <= 1'b1;
            end
          end
        end
        RD: begin
          rdata <= load_word_c;
          state <= RESP;
          done  <= 1'b1;
        end
        RMW_RD: begin
          state     <= WR;
          MemWrite  <= 1'b1;
          mem_wdata <= store_word_c;
        end
        WR: begin
          state <= RESP;
          done  <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory and a behavioural reference model.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [2:0]        funct3 = 3'b000;
  logic [31:0]       addr = 32'd0;
  logic [31:0]       wdata = 32'd0;
  logic              ready, done, err;
  logic [31:0]       rdata;
  logic              MemRead, MemWrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        init_done = 1'b0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] seed(input int i);
    if (i == 5) return 32'h8899AABB;
    return 32'(i) * 32'h01000193 + 32'h0F0F1234;
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
      init_done <= 1'b1;
    end else if (MemWrite) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle invariants on the memory interface and result register.
  always @(negedge clk) begin
    if (reset_n) begin
      check("mem_rw_exclusive", 32'(MemRead & MemWrite), 32'd0);
      if (!MemWrite) check("mem_wdata_idle", mem_wdata, 32'd0);
      check("done_vs_ready", 32'(done & ready), 32'd0);
      if (!done) check("rdata_hold", rdata, exp_rdata);
    end
  end

  // Reference behaviour of one access from the width/alignment rules.
  task automatic model(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output int lat,
                       output logic [31:0] ld, output logic [31:0] st);
    logic [31:0] word, bt, hw, bmask, hmask;
    int sh8, sh16;
    word  = ref_mem[int'(a[ADDR_W+1:2])];
    sh8   = 8 * int'(a[1:0]);
    sh16  = 16 * int'(a[1]);
    bt    = (word >> sh8) & 32'hFF;
    hw    = (word >> sh16) & 32'hFFFF;
    bmask = 32'hFF << sh8;
    hmask = 32'hFFFF << sh16;
    e = (f == 3) || (f == 6) || (f == 7) || (w && f >= 4) ||
        ((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 2'b00);
    case (f)
      3'd0:    ld = bt[7]  ? (bt | 32'hFFFFFF00) : bt;
      3'd1:    ld = hw[15] ? (hw | 32'hFFFF0000) : hw;
      3'd4:    ld = bt;
      3'd5:    ld = hw;
      default: ld = word;
    endcase
    case (f)
      3'd0:    st = (word & ~bmask) | ((d & 32'hFF) << sh8);
      3'd1:    st = (word & ~hmask) | ((d & 32'hFFFF) << sh16);
      default: st = d;
    endcase
    lat = e ? 1 : ((!w || f == 3'd2) ? 2 : 3);
  endtask

  task automatic op(input string name, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d);
    logic e, got;
    int lat, cyc, reads, writes, wi;
    logic [31:0] ld, st;
    model(w, f, a, d, e, lat, ld, st);
    wi = int'(a[ADDR_W+1:2]);
    @(negedge clk);
    check({name, ".ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    cyc = 0; reads = 0; writes = 0; got = 1'b0;
    while (cyc < 8 && !got) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      if (MemRead) reads++;
      if (MemWrite) writes++;
      if (MemRead || MemWrite) check({name, ".mem_addr"}, 32'(mem_addr), 32'(wi));
      if (MemWrite) check({name, ".mem_wdata"}, mem_wdata, st);
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: no done within %0d cycles", name, cyc);
    end else begin
      check({name, ".latency"}, 32'(cyc), 32'(lat));
      check({name, ".err"}, 32'(err), 32'(e));
      if (!e && !w) exp_rdata = ld;
      check({name, ".rdata"}, rdata, exp_rdata);
      check({name, ".reads"}, 32'(reads), (e || (w && f == 3'd2)) ? 32'd0 : 32'd1);
      check({name, ".writes"}, 32'(writes), (!e && w) ? 32'd1 : 32'd0);
      if (!e && w) ref_mem[wi] = st;
      check({name, ".mem"}, mem[wi], ref_mem[wi]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_cnt, done_cnt, read_cnt, last_rdy, gap_bad, bound;
    logic [31:0] cont_ld;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);

    repeat (3) @(negedge clk);
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.memread", 32'(MemRead), 32'd0);
    check("rst.memwrite", 32'(MemWrite), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;

    op("lb_0x16", 1'b0, 3'b000, 32'h16, 32'd0);
    check("lit.lb_0x16", rdata, 32'hFFFFFF99);
    op("lhu_0x16", 1'b0, 3'b101, 32'h16, 32'd0);
    check("lit.lhu_0x16", rdata, 32'h00008899);
    op("lw_0x14", 1'b0, 3'b010, 32'h14, 32'd0);
    check("lit.lw_0x14", rdata, 32'h8899AABB);
    op("sw_mis", 1'b1, 3'b010, 32'h12, 32'hDEADBEEF);
    check("lit.sw_mis_err", 32'(err), 32'd1);
    check("lit.sw_mis_rdata", rdata, 32'h8899AABB);
    op("sb_0x15", 1'b1, 3'b000, 32'h15, 32'h123456CC);
    check("lit.sb_0x15_mem", mem[5], 32'h8899CCBB);
    op("lb_0x15", 1'b0, 3'b000, 32'h15, 32'd0);
    check("lit.lb_0x15", rdata, 32'hFFFFFFCC);
    op("sh_0x22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
    op("lh_0x22", 1'b0, 3'b001, 32'h22, 32'd0);
    check("lit.lh_0x22", rdata, 32'hFFFFBEEF);
    op("lbu_0x23", 1'b0, 3'b100, 32'h23, 32'd0);
    op("sh_0x20", 1'b1, 3'b001, 32'h20, 32'hFFFF1234);
    op("lh_0x20", 1'b0, 3'b001, 32'h20, 32'd0);
    op("ill_011", 1'b0, 3'b011, 32'h20, 32'd0);
    op("ill_sbu", 1'b1, 3'b100, 32'h20, 32'h55);
    op("ill_shu", 1'b1, 3'b101, 32'h20, 32'h55);
    op("lh_mis", 1'b0, 3'b001, 32'h21, 32'd0);
    op("ill_111", 1'b0, 3'b111, 32'h24, 32'd0);
    op("sw_0x30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
    op("lw_0x30", 1'b0, 3'b010, 32'h30, 32'd0);
    op("lbu_0x33", 1'b0, 3'b100, 32'h33, 32'd0);

    // Reset in the write cycle of a halfword store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h40; wdata = 32'h0000ABCD;
    bound = 0;
    while (bound < 6 && !MemWrite) begin
      @(negedge clk);
      bound++;
      req = 1'b0;
    end
    if (!MemWrite) begin
      n_cmp++; n_bad++;
      $display("FAIL rst_wr.timeout: MemWrite never seen in %0d cycles", bound);
    end
    reset_n = 1'b0;
    exp_rdata = 32'd0;
    #1;
    check("rst_wr.memwrite", 32'(MemWrite), 32'd0);
    check("rst_wr.ready", 32'(ready), 32'd1);
    check("rst_wr.done", 32'(done), 32'd0);
    check("rst_wr.rdata", rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wr.mem_untouched", mem[16], ref_mem[16]);
    op("lw_after_rst", 1'b0, 3'b010, 32'h40, 32'd0);

    // Continuous request: one accept every third cycle, none while busy.
    @(negedge clk);
    cont_ld = ref_mem[12];
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h30; wdata = 32'd0;
    ready_cnt = 0; done_cnt = 0; read_cnt = 0; last_rdy = -3; gap_bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (ready) begin
        if (k - last_rdy != 3) gap_bad++;
        last_rdy = k;
        ready_cnt++;
      end
      if (MemRead) read_cnt++;
      if (done) begin
        done_cnt++;
        exp_rdata = cont_ld;
        check("cont.rdata", rdata, cont_ld);
      end
    end
    req = 1'b0;
    check("cont.ready_cnt", 32'(ready_cnt), 32'd4);
    check("cont.done_cnt", 32'(done_cnt), 32'd4);
    check("cont.read_cnt", 32'(read_cnt), 32'd4);
    check("cont.gap", 32'(gap_bad), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
